// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch front end.
package if_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DELIVER = 2'd2
    } fetch_state_t;

    // Word presented to ID when nothing has been fetched yet.
    localparam logic [31:0] NOP_INST = 32'd0;

    // Sequential instruction stride in bytes.
    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/if_redirect_buf.sv
// Holds a branch redirect that arrived while a memory request was in flight.
// A newer set overwrites the stored target; clear drops the pending flag once
// the request completes and the redirect has been acted on.
module if_redirect_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_clear,
    output logic              o_pend,
    output logic [ADDR_W-1:0] o_addr
);

    logic              r_pend;
    logic [ADDR_W-1:0] r_addr;

    // Pending flag and target: set/overwrite wins over clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= 1'b0;
            r_addr <= '0;
        end else if (i_set) begin
            r_pend <= 1'b1;
            r_addr <= i_set_addr;
        end else if (i_clear) begin
            r_pend <= 1'b0;
        end
    end

    assign o_pend = r_pend;
    assign o_addr = r_addr;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs a req/ack handshake against a
// variable-latency instruction memory and hands one instruction at a time
// to ID. Branches that land mid-request are parked in the redirect buffer
// and the returning (stale) word is dropped.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter int               DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchAddr,
    input  logic              freeze,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              valid_out,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instruction
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_next;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] w_fetch_pc_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] w_instr_next;
    logic              r_valid;
    logic              w_valid_next;

    logic              w_ack;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_redir_set;
    logic              w_redir_clr;
    logic              w_redir_pend;
    logic [ADDR_W-1:0] w_redir_addr;

    // The memory interface is driven purely from registered state.
    assign mem_req  = (r_state == ST_FETCH);
    assign mem_addr = r_fetch_pc;
    // An ack with no request outstanding is meaningless and is dropped.
    assign w_ack    = mem_ack & mem_req;
    // Sequential successor; natural wrap at the top of the address space.
    assign w_pc_inc = r_fetch_pc + ADDR_W'(PC_INC);

    if_redirect_buf #(
        .ADDR_W (ADDR_W)
    ) u_redirect_buf (
        .clk        (clk),
        .rst        (rst),
        .i_set      (w_redir_set),
        .i_set_addr (branchAddr),
        .i_clear    (w_redir_clr),
        .o_pend     (w_redir_pend),
        .o_addr     (w_redir_addr)
    );

    // State, fetch PC and the delivered instruction registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_RESET;
            r_fetch_pc <= RESET_PC;
            r_pc       <= '0;
            r_instr    <= DATA_W'(NOP_INST);
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_pc       <= w_pc_next;
            r_instr    <= w_instr_next;
            r_valid    <= w_valid_next;
        end
    end

    // Next-state and register-update decisions; everything holds by default.
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_pc_next       = r_pc;
        w_instr_next    = r_instr;
        w_valid_next    = r_valid;
        w_redir_set     = 1'b0;
        w_redir_clr     = 1'b0;

        case (r_state)
            ST_RESET: begin
                w_state_next = ST_FETCH;
                if (branchTaken) begin
                    w_fetch_pc_next = branchAddr;
                end
            end

            ST_FETCH: begin
                w_valid_next = 1'b0;
                if (w_ack) begin
                    w_redir_clr = 1'b1;
                    if (branchTaken) begin
                        // A branch in the ack cycle beats any parked redirect.
                        w_fetch_pc_next = branchAddr;
                    end else if (w_redir_pend) begin
                        w_fetch_pc_next = w_redir_addr;
                    end else begin
                        w_instr_next    = mem_rdata;
                        w_pc_next       = w_pc_inc;
                        w_valid_next    = 1'b1;
                        w_fetch_pc_next = w_pc_inc;
                        w_state_next    = ST_DELIVER;
                    end
                end else if (branchTaken) begin
                    // fetch_pc must stay put while the request is open.
                    w_redir_set = 1'b1;
                end
            end

            ST_DELIVER: begin
                if (branchTaken) begin
                    w_valid_next    = 1'b0;
                    w_fetch_pc_next = branchAddr;
                    w_state_next    = ST_FETCH;
                end else if (!freeze) begin
                    w_valid_next = 1'b0;
                    w_state_next = ST_FETCH;
                end
            end

            default: begin
                w_state_next = ST_RESET;
            end
        endcase
    end

    assign valid_out   = r_valid;
    assign pc          = r_pc;
    assign instruction = r_instr;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomized bench for if_fetch_ctrl: a variable-latency memory plus a
// transaction-level model of which addresses should be delivered, with a
// scoreboard queue drained by an independent output monitor.
module tb_if_fetch_ctrl;

    localparam int          AW       = 32;
    localparam int          DW       = 32;
    localparam logic [31:0] RST_PC   = 32'h0;

    logic          clk = 1'b0;
    logic          rst;
    logic          branchTaken;
    logic [AW-1:0] branchAddr;
    logic          freeze;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          valid_out;
    logic [AW-1:0] pc;
    logic [DW-1:0] instruction;

    if_fetch_ctrl #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .branchTaken (branchTaken),
        .branchAddr  (branchAddr),
        .freeze      (freeze),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .valid_out   (valid_out),
        .pc          (pc),
        .instruction (instruction)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_deliv  = 0;

    // Stimulus knobs, changed by the main sequence.
    int          max_lat  = 0;
    int          br_pct   = 0;
    int          frz_pct  = 0;
    int          spur_pct = 0;
    bit          inject   = 1'b0;
    logic [31:0] inject_addr = 32'h0;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Driver, memory and reference model. Model rule: the next delivered
    // address is the target of the most recent branch, otherwise the last
    // delivered address + 4; a completed request is thrown away if any branch
    // arrived while it was open or in its completion cycle.
    initial begin : driver
        logic [31:0] model_addr;
        bit          dirty;
        int          wait_cnt;
        bit          br;
        bit          ack;
        logic [31:0] baddr;
        logic [31:0] rdata;
        model_addr  = RST_PC;
        dirty       = 1'b0;
        wait_cnt    = 0;
        branchTaken = 1'b0;
        branchAddr  = '0;
        freeze      = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                model_addr  = RST_PC;
                dirty       = 1'b0;
                wait_cnt    = 0;
                sb_q.delete();
                branchTaken = 1'b0;
                mem_ack     = 1'b0;
                freeze      = 1'b0;
                continue;
            end
            br    = inject || ($urandom_range(0, 99) < br_pct);
            if (inject) baddr = inject_addr;
            else if ($urandom_range(0, 7) == 0) baddr = 32'hFFFF_FFFC;
            else baddr = 32'($urandom_range(0, 63)) << 2;
            inject = 1'b0;
            ack   = 1'b0;
            rdata = $urandom;
            if (mem_req) begin
                if (wait_cnt == 0) begin
                    ack      = 1'b1;
                    rdata    = mem_word(mem_addr);
                    wait_cnt = $urandom_range(0, max_lat);
                end else begin
                    wait_cnt--;
                end
            end else if ($urandom_range(0, 99) < spur_pct) begin
                ack = 1'b1;
            end
            branchTaken = br;
            branchAddr  = br ? baddr : 32'($urandom);
            freeze      = ($urandom_range(0, 99) < frz_pct);
            mem_ack     = ack;
            mem_rdata   = rdata;

            if (ack && mem_req) begin
                if (br) begin
                    model_addr = baddr;
                end else if (!dirty) begin
                    check("fetch_addr", mem_addr, model_addr);
                    sb_q.push_back('{pc: model_addr + 32'd4, instr: mem_word(model_addr)});
                    model_addr = model_addr + 32'd4;
                end
                dirty = 1'b0;
            end else if (br) begin
                model_addr = baddr;
                if (mem_req) dirty = 1'b1;
            end
        end
    end

    // Output monitor: pops an expectation on each new delivery, checks that
    // outputs hold while delivered and that consumption drops valid_out.
    initial begin : monitor
        bit   prev_valid;
        bit   have_exp;
        exp_t cur;
        prev_valid = 1'b0;
        have_exp   = 1'b0;
        cur        = '{pc: 32'h0, instr: 32'h0};
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                prev_valid = 1'b0;
                have_exp   = 1'b0;
                continue;
            end
            if (prev_valid && (branchTaken || !freeze))
                check("valid_drop", {31'b0, valid_out}, 32'd0);
            if (valid_out && !prev_valid) begin
                n_deliv++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_delivery actual pc=%h required=none", pc);
                    have_exp = 1'b0;
                end else begin
                    cur      = sb_q.pop_front();
                    have_exp = 1'b1;
                end
            end
            if (valid_out && have_exp) begin
                check("pc", pc, cur.pc);
                check("instruction", instruction, cur.instr);
                check("mem_req_in_deliver", {31'b0, mem_req}, 32'd0);
            end
            prev_valid = valid_out;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int  edges;
        bit  found;
        bit  pv;
        rst = 1'b0;
        #2;
        check("rst_valid_out", {31'b0, valid_out}, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_instruction", instruction, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        // Zero-wait memory: first delivery two edges after release.
        edges = 0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk);
            #2;
            edges++;
            if (valid_out) found = 1'b1;
        end
        check("first_valid_latency", 32'(edges), 32'd2);
        check("first_pc", pc, RST_PC + 32'd4);

        repeat (20) @(posedge clk);

        // Waits, branches, freezes and stray acks.
        max_lat = 3; br_pct = 15; frz_pct = 30; spur_pct = 10;
        repeat (400) @(posedge clk);
        // Dense branches: several redirects per outstanding request.
        br_pct = 45; frz_pct = 20;
        repeat (400) @(posedge clk);

        // Wrap at the top of the address space.
        br_pct = 0; frz_pct = 0; max_lat = 1;
        repeat (5) @(posedge clk);
        inject_addr = 32'hFFFF_FFFC;
        inject      = 1'b1;
        @(negedge clk);
        #1 pv = valid_out;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #2;
            if (valid_out && !pv) found = 1'b1;
            pv = valid_out;
        end
        check("wrap_found", {31'b0, found}, 32'd1);
        check("wrap_pc", pc, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #2;
            if (valid_out && !pv) found = 1'b1;
            pv = valid_out;
        end
        check("after_wrap_pc", pc, 32'h4);

        // Reset asserted while a request is outstanding.
        max_lat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #3;
            if (mem_req) found = 1'b1;
        end
        check("midreq_found", {31'b0, found}, 32'd1);
        rst = 1'b0;
        #1;
        check("midreq_valid_out", {31'b0, valid_out}, 32'd0);
        check("midreq_pc", pc, 32'd0);
        check("midreq_instruction", instruction, 32'd0);
        check("midreq_mem_req", {31'b0, mem_req}, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge clk);
            #2;
            if (mem_req) found = 1'b1;
        end
        check("refetch_addr", mem_addr, RST_PC);

        br_pct = 20; frz_pct = 20; spur_pct = 10;
        repeat (150) @(posedge clk);

        // Drain and make sure every expected delivery appeared.
        br_pct = 0; frz_pct = 0; spur_pct = 0;
        repeat (20) @(posedge clk);
        #2;
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        check("enough_deliveries", {31'b0, (n_deliv > 50)}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
